// File: rtl/seg_display_scheduler_pkg.sv
// Shared seven-segment display definitions: digit codes, owner encoding,
// packed-digit layout and scheduler FSM states.
// Ports: none (package). Also imported by the digit driver and game logic.
package seg_display_scheduler_pkg;

  // Packed layout: four 4-bit digits in 16 bits, nibble 0 = rightmost digit.
  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int PACKED_W   = DIGIT_W * NUM_DIGITS;

  // Driver renders BLANK_CODE as all segments off; WILD_CODE is the "A" glyph.
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
  localparam logic [DIGIT_W-1:0] WILD_CODE  = 4'hA;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_SRC  = 2'd1,
    OWN_MSG  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW_SRC,
    ST_SHOW_MSG
  } disp_state_e;

  // Replicate one code into every digit position.
  function automatic logic [PACKED_W-1:0] fill_digits(input logic [DIGIT_W-1:0] code);
    return {NUM_DIGITS{code}};
  endfunction

endpackage

// File: rtl/seg_prio_arbiter.sv
// Fixed-priority picker: lowest set request bit wins.
// Ports: req_i (request vector) -> vld_o (any request), idx_o (winning index).
// Purely combinational.
module seg_prio_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    vld_o = |req_i;
    idx_o = '0;
    // Walk from the top down so the lowest asserted index is the last write.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Chooses who owns the 4-digit display: timed messages first, then level
// request sources by fixed priority; applies per-source blinking.
// Ports: clk/rst, src_req/src_data/src_blink (sources), msg_valid/msg_data/
// msg_ready (message handshake), digit0..3, owner, owner_idx (registered).
module seg_display_scheduler
  import seg_display_scheduler_pkg::*;
#(
  parameter int          NUM_SRC     = 3,
  parameter int          HOLD_CYCLES = 200000000,
  parameter int          BLINK_HALF  = 25000000,
  parameter logic [3:0]  BLANK_CODE  = seg_display_scheduler_pkg::BLANK_CODE,
  localparam int         IW          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SRC-1:0]    src_req,
  input  logic [16*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]    src_blink,
  input  logic                  msg_valid,
  input  logic [15:0]           msg_data,
  output logic                  msg_ready,
  output logic [3:0]            digit0,
  output logic [3:0]            digit1,
  output logic [3:0]            digit2,
  output logic [3:0]            digit3,
  output logic [1:0]            owner,
  output logic [IW-1:0]         owner_idx
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  disp_state_e         state_q, state_d;
  logic [PACKED_W-1:0] act_q, act_d;
  logic [PACKED_W-1:0] pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_ph_q, blink_ph_d;
  owner_e              owner_q, owner_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [PACKED_W-1:0] dig_q, dig_d;

  logic                arb_vld;
  logic [IW-1:0]       arb_idx;
  logic [PACKED_W-1:0] sel_dat;
  logic                sel_blk;
  logic                accept;
  logic                hold_done;

  seg_prio_arbiter #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_arb (
    .req_i (src_req),
    .vld_o (arb_vld),
    .idx_o (arb_idx)
  );

  assign msg_ready = ~pend_vld_q;
  assign accept    = msg_valid & ~pend_vld_q;
  assign hold_done = (hold_q == HW'(HOLD_CYCLES - 1));

  assign digit0    = dig_q[3:0];
  assign digit1    = dig_q[7:4];
  assign digit2    = dig_q[11:8];
  assign digit3    = dig_q[15:12];
  assign owner     = owner_q;
  assign owner_idx = idx_q;

  // Data and blink enable of the currently winning source.
  always_comb begin : src_mux
    sel_dat = '0;
    sel_blk = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_dat = src_data[i*PACKED_W +: PACKED_W];
        sel_blk = src_blink[i];
      end
    end
  end

  always_comb begin : next_state
    state_d     = state_q;
    act_d       = act_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    hold_d      = hold_q;
    owner_d     = OWN_IDLE;
    idx_d       = '0;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    dig_d       = fill_digits(BLANK_CODE);

    // A running message is never cut short; anything waiting in pending
    // is only promoted once the current hold has run out.
    if (state_q == ST_SHOW_MSG && !hold_done) begin
      hold_d = hold_q + HW'(1);
    end else if (pend_vld_q) begin
      state_d    = ST_SHOW_MSG;
      act_d      = pend_q;
      pend_vld_d = 1'b0;
      hold_d     = '0;
    end else begin
      hold_d  = '0;
      state_d = arb_vld ? ST_SHOW_SRC : ST_IDLE;
    end

    // Accept only into an empty buffer, so this never collides with the
    // promotion above (which needs the buffer full).
    if (accept) begin
      pend_vld_d = 1'b1;
      pend_d     = msg_data;
    end

    case (state_d)
      ST_SHOW_SRC: begin
        owner_d = OWN_SRC;
        idx_d   = arb_idx;
      end
      ST_SHOW_MSG: owner_d = OWN_MSG;
      default:     owner_d = OWN_IDLE;
    endcase

    // Blink timing restarts in the visible phase for every new owner.
    if (owner_d != owner_q || idx_d != idx_q) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end

    case (state_d)
      ST_SHOW_MSG: dig_d = act_d;
      ST_SHOW_SRC: dig_d = (sel_blk && blink_ph_d) ? fill_digits(BLANK_CODE) : sel_dat;
      default:     dig_d = fill_digits(BLANK_CODE);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      act_q       <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      owner_q     <= OWN_IDLE;
      idx_q       <= '0;
      dig_q       <= fill_digits(BLANK_CODE);
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      owner_q     <= owner_d;
      idx_q       <= idx_d;
      dig_q       <= dig_d;
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench for seg_display_scheduler: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
// Ports: none (top-level bench).
module tb_seg_display_scheduler;

  localparam int NS   = 3;
  localparam int HOLD = 10;
  localparam int BH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  src_req;
  logic [47:0] src_data;
  logic [2:0]  src_blink;
  logic        msg_valid;
  logic [15:0] msg_data;
  logic        msg_ready;
  logic [3:0]  digit0, digit1, digit2, digit3;
  logic [1:0]  owner;
  logic [1:0]  owner_idx;
  logic [15:0] dig_all;

  int checks   = 0;
  int failures = 0;

  assign dig_all = {digit3, digit2, digit1, digit0};

  always #5 clk = ~clk;

  seg_display_scheduler #(
    .NUM_SRC     (NS),
    .HOLD_CYCLES (HOLD),
    .BLINK_HALF  (BH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_req   (src_req),
    .src_data  (src_data),
    .src_blink (src_blink),
    .msg_valid (msg_valid),
    .msg_data  (msg_data),
    .msg_ready (msg_ready),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .owner     (owner),
    .owner_idx (owner_idx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the pending slot, the shown message with its remaining cycles,
  // and how long the current owner has held the display (for blinking).
  bit          m_init = 1'b0;
  bit          m_pv;
  logic [15:0] m_pd, m_msg;
  int          m_mode, m_idx, m_left, m_age;
  logic [15:0] e_dig;
  int          e_own, e_idx;
  bit          e_rdy;

  initial forever begin
    int pmode, pidx;
    bit acc;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_init = 1'b1; m_pv = 1'b0; m_pd = '0; m_msg = '0;
      m_mode = 0; m_idx = 0; m_left = 0; m_age = 0;
      e_dig = 16'hFFFF; e_own = 0; e_idx = 0; e_rdy = 1'b1;
    end else begin
      pmode = m_mode;
      pidx  = m_idx;
      acc   = msg_valid && !m_pv;
      if (m_mode == 2 && m_left > 1) begin
        m_left--;
      end else if (m_pv) begin
        m_mode = 2; m_idx = 0; m_msg = m_pd; m_left = HOLD; m_pv = 1'b0;
      end else begin
        m_mode = 0; m_idx = 0;
        for (int i = NS - 1; i >= 0; i--)
          if (src_req[i]) begin m_mode = 1; m_idx = i; end
      end
      if (acc) begin m_pv = 1'b1; m_pd = msg_data; end
      if (m_mode != pmode || m_idx != pidx) m_age = 0; else m_age++;
      e_own = m_mode;
      e_idx = m_idx;
      e_rdy = !m_pv;
      if (m_mode == 2) e_dig = m_msg;
      else if (m_mode == 1) begin
        e_dig = src_data[m_idx*16 +: 16];
        if (src_blink[m_idx] && ((m_age / BH) % 2 == 1)) e_dig = 16'hFFFF;
      end else e_dig = 16'hFFFF;
    end
  end

  // Compare on the falling edge, well away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("model_digits", dig_all, e_dig);
      chk("model_owner", owner, e_own);
      if (e_own == 1) chk("model_owner_idx", owner_idx, e_idx);
      chk("model_msg_ready", msg_ready, e_rdy);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [15:0] d);
    msg_valid = 1'b1;
    msg_data  = d;
    chk("send_ready", msg_ready, 1);
    tick();
    msg_valid = 1'b0;
  endtask

  logic [15:0] q[$];
  int          tr_own[40];
  logic [15:0] tr_dig[40];
  bit          tr_rdy[40];
  logic [11:0] pat;
  logic [7:0]  pat2;
  int          n, c1, c2, c3;
  bit          acc;

  initial begin
    rst = 1'b1; src_req = '0; src_data = '0; src_blink = '0;
    msg_valid = 1'b0; msg_data = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_digits", dig_all, 16'hFFFF);
    chk("rst_owner", owner, 0);
    chk("rst_ready", msg_ready, 1);

    // Arbitration
    src_req = 3'b100; src_data[47:32] = 16'h4321; tick();
    chk("arb_src2_digits", dig_all, 16'h4321);
    chk("arb_src2_owner", owner, 1);
    chk("arb_src2_idx", owner_idx, 2);
    src_req = 3'b101; src_data[15:0] = 16'h0009; tick();
    chk("preempt_idx", owner_idx, 0);
    chk("preempt_digit0", digit0, 9);
    src_req = 3'b100; tick();
    chk("drop_idx", owner_idx, 2);
    chk("drop_digits", dig_all, 16'h4321);

    // Single message over src 1
    src_req = 3'b010; src_data[31:16] = 16'h5678; tick();
    chk("src1_idx", owner_idx, 1);
    send(16'hAAAA);
    chk("msg_pending_only", owner, 1);
    n = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (owner == 2 && dig_all == 16'hAAAA) n++; else break;
    end
    chk("msg_hold_len", n, 10);
    chk("msg_return_owner", owner, 1);
    chk("msg_return_idx", owner_idx, 1);
    chk("msg_return_digits", dig_all, 16'h5678);

    // Back-to-back messages, valid held until accepted
    src_req = 3'b000; tick();
    q.push_back(16'h1111); q.push_back(16'h2222); q.push_back(16'h3333);
    for (int i = 0; i < 40; i++) begin
      msg_valid = (q.size() > 0);
      if (q.size() > 0) msg_data = q[0];
      acc = msg_valid && msg_ready;
      tick();
      if (acc) void'(q.pop_front());
      tr_own[i] = owner; tr_dig[i] = dig_all; tr_rdy[i] = msg_ready;
    end
    msg_valid = 1'b0;
    c1 = 0; c2 = 0; c3 = 0;
    for (int i = 0; i < 40; i++) begin
      if (tr_own[i] == 2 && tr_dig[i] == 16'h1111) c1++;
      if (tr_own[i] == 2 && tr_dig[i] == 16'h2222) c2++;
      if (tr_own[i] == 2 && tr_dig[i] == 16'h3333) c3++;
    end
    chk("b2b_cnt1", c1, 10);
    chk("b2b_cnt2", c2, 10);
    chk("b2b_cnt3", c3, 10);
    chk("b2b_first_idle", tr_own[0], 0);
    chk("b2b_1_start", tr_dig[1], 16'h1111);
    chk("b2b_2_start", tr_dig[11], 16'h2222);
    chk("b2b_3_start", tr_dig[21], 16'h3333);
    chk("b2b_3_end", tr_dig[30], 16'h3333);
    chk("b2b_idle_after", tr_own[31], 0);
    chk("b2b_ready_low", tr_rdy[5], 0);
    chk("b2b_ready_after_load", tr_rdy[11], 1);

    // Blink
    src_req = 3'b001; src_blink = 3'b001; src_data[15:0] = 16'h1234;
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      pat[i] = (dig_all != 16'hFFFF);
    end
    chk("blink_pattern", pat, 12'hF0F);
    send(16'hA0A0);
    tick();
    chk("blink_preempt_owner", owner, 2);
    for (int i = 0; i < 15; i++) begin
      if (owner == 1) break;
      tick();
    end
    chk("blink_return_owner", owner, 1);
    pat2 = '0;
    for (int i = 0; i < 8; i++) begin
      pat2[i] = (dig_all != 16'hFFFF);
      if (i < 7) tick();
    end
    chk("blink_restart_pattern", pat2, 8'h0F);

    // Message offered on the expiry edge
    src_req = 3'b000; src_blink = 3'b000; tick();
    send(16'h5555);
    tick();
    chk("exp_m1_digits", dig_all, 16'h5555);
    repeat (9) tick();
    chk("exp_m1_last", dig_all, 16'h5555);
    msg_valid = 1'b1; msg_data = 16'h6666;
    chk("exp_offer_ready", msg_ready, 1);
    tick();
    msg_valid = 1'b0;
    chk("exp_gap_owner", owner, 0);
    chk("exp_pending", msg_ready, 0);
    n = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (owner == 2 && dig_all == 16'h6666) n++; else break;
    end
    chk("exp_m2_hold_len", n, 10);
    chk("exp_m2_then_idle", owner, 0);

    // Reset in the middle of a message with pending full
    send(16'h7777);
    tick();
    send(16'h8888);
    chk("rst_mid_pend_full", msg_ready, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_digits", dig_all, 16'hFFFF);
    chk("rst_mid_owner", owner, 0);
    chk("rst_mid_ready", msg_ready, 1);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("rst_mid_discard_owner", owner, 0);
    chk("rst_mid_discard_digits", dig_all, 16'hFFFF);

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) begin
        src_req   = 3'($urandom);
        src_blink = 3'($urandom);
      end
      src_data  = 48'({$urandom(), $urandom()});
      msg_valid = ($urandom_range(31) == 0);
      msg_data  = 16'($urandom);
      if (c == 1500) rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    msg_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
